// File: rtl/pmp_csr_regfile.sv
// PMP CSR register file: pmpcfg/pmpaddr storage with WARL and lock rules,
// valid/ready CSR access channel and registered NAPOT compare masks.

typedef struct packed {
    logic       lock;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
} pmp_cfg_t;

module pmp_csr_regfile #(
    parameter int PMP_CHANNEL_NUM = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_req_vld,
    output logic                  csr_req_rdy,
    input  logic                  csr_req_wr,
    input  logic [11:0]           csr_req_addr,
    input  logic [31:0]           csr_req_wdata,
    output logic                  csr_rsp_vld,
    input  logic                  csr_rsp_rdy,
    output logic [31:0]           csr_rsp_rdata,
    output logic                  csr_rsp_err,
    output logic                  pmp_upd_busy,
    output pmp_cfg_t              v_pmp_cfg        [PMP_CHANNEL_NUM],
    output logic [ADDR_WIDTH-1:0] v_pmp_addr       [PMP_CHANNEL_NUM],
    output logic [ADDR_WIDTH-1:0] v_pmp_napot_mask [PMP_CHANNEL_NUM]
);

    localparam int N  = PMP_CHANNEL_NUM;
    localparam int AW = ADDR_WIDTH;

    pmp_cfg_t        r_cfg  [N];
    logic [AW-1:0]   r_addr [N];
    logic [AW-1:0]   r_mask [N];
    logic            r_rsp_vld;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic            r_busy;

    logic            w_acc;
    logic            w_is_cfg;
    logic            w_is_addr;
    logic            w_err;
    logic [5:0]      w_aidx;
    logic [31:0]     w_rdata;
    logic            w_commit;
    logic [N-1:0]    w_cfg_we;
    logic [N-1:0]    w_addr_we;
    logic [N-1:0]    w_tor_lk;
    pmp_cfg_t        w_cfg_new [N];
    logic [AW-1:0]   w_napot   [N];

    assign csr_req_rdy = ~r_rsp_vld | csr_rsp_rdy;
    assign w_acc       = csr_req_vld & csr_req_rdy;

    assign w_is_cfg  = (csr_req_addr[11:4] == 8'h3A);
    assign w_is_addr = (csr_req_addr >= 12'h3B0) && (csr_req_addr <= 12'h3EF);
    assign w_err     = ~w_is_cfg & ~w_is_addr;
    assign w_aidx    = 6'(csr_req_addr - 12'h3B0);

    for (genvar g = 0; g < N; g++) begin : g_ent
        localparam int B = 8 * (g % 4);

        assign w_cfg_we[g] = w_is_cfg
                           && (csr_req_addr[3:0] == 4'(g / 4))
                           && !r_cfg[g].lock;

        // Reserved bits dropped; W without R collapses to W=0.
        assign w_cfg_new[g] = '{
            lock: csr_req_wdata[B+7],
            rsvd: 2'b00,
            a:    csr_req_wdata[B+4:B+3],
            x:    csr_req_wdata[B+2],
            w:    csr_req_wdata[B+1] & csr_req_wdata[B],
            r:    csr_req_wdata[B]
        };

        if (g + 1 < N) begin : g_tor
            assign w_tor_lk[g] = r_cfg[g+1].lock && (r_cfg[g+1].a == 2'b01);
        end else begin : g_last
            assign w_tor_lk[g] = 1'b0;
        end

        assign w_addr_we[g] = w_is_addr
                            && (w_aidx == 6'(g))
                            && !r_cfg[g].lock
                            && !w_tor_lk[g];

        assign w_napot[g] = ~(r_addr[g] ^ (r_addr[g] + AW'(1)));
    end

    assign w_commit = w_acc & csr_req_wr & ((|w_cfg_we) | (|w_addr_we));

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_is_cfg && (csr_req_addr[3:0] == 4'(i / 4)))
                w_rdata[8*(i%4) +: 8] = r_cfg[i];
            if (w_is_addr && (w_aidx == 6'(i)))
                w_rdata = 32'(r_addr[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_cfg[i]  <= '0;
                r_addr[i] <= '0;
            end
        end else if (w_acc && csr_req_wr) begin
            for (int i = 0; i < N; i++) begin
                if (w_cfg_we[i])
                    r_cfg[i] <= w_cfg_new[i];
                if (w_addr_we[i])
                    r_addr[i] <= csr_req_wdata[AW-1:0];
            end
        end
    end

    // Masks trail the committed registers by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                r_mask[i] <= '1;
        end else begin
            for (int i = 0; i < N; i++)
                r_mask[i] <= (r_cfg[i].a == 2'b11) ? w_napot[i] : '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_vld <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_busy <= w_commit;
            if (w_acc) begin
                r_rsp_vld <= 1'b1;
                r_rdata   <= csr_req_wr ? 32'h0 : w_rdata;
                r_err     <= w_err;
            end else if (csr_rsp_rdy) begin
                r_rsp_vld <= 1'b0;
            end
        end
    end

    assign csr_rsp_vld      = r_rsp_vld;
    assign csr_rsp_rdata    = r_rdata;
    assign csr_rsp_err      = r_err;
    assign pmp_upd_busy     = r_busy;
    assign v_pmp_cfg        = r_cfg;
    assign v_pmp_addr       = r_addr;
    assign v_pmp_napot_mask = r_mask;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Bench for pmp_csr_regfile: transaction-level reference model plus
// directed literal checks and randomized CSR traffic with periodic resets.

module tb_pmp_csr_regfile;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_req_vld = 1'b0;
    logic        csr_req_rdy;
    logic        csr_req_wr = 1'b0;
    logic [11:0] csr_req_addr = '0;
    logic [31:0] csr_req_wdata = '0;
    logic        csr_rsp_vld;
    logic        csr_rsp_rdy = 1'b1;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_err;
    logic        pmp_upd_busy;
    pmp_cfg_t    v_pmp_cfg        [N];
    logic [31:0] v_pmp_addr       [N];
    logic [31:0] v_pmp_napot_mask [N];

    int checks = 0;
    int errors = 0;

    pmp_csr_regfile #(.PMP_CHANNEL_NUM(N), .ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .csr_req_vld      (csr_req_vld),
        .csr_req_rdy      (csr_req_rdy),
        .csr_req_wr       (csr_req_wr),
        .csr_req_addr     (csr_req_addr),
        .csr_req_wdata    (csr_req_wdata),
        .csr_rsp_vld      (csr_rsp_vld),
        .csr_rsp_rdy      (csr_rsp_rdy),
        .csr_rsp_rdata    (csr_rsp_rdata),
        .csr_rsp_err      (csr_rsp_err),
        .pmp_upd_busy     (pmp_upd_busy),
        .v_pmp_cfg        (v_pmp_cfg),
        .v_pmp_addr       (v_pmp_addr),
        .v_pmp_napot_mask (v_pmp_napot_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%08h required=%08h @%0t",
                         nm, act, exp, $time);
        end
    endtask

    // Reference model, advanced once per rising edge.
    logic [7:0]  m_cfg  [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_mask [N];
    logic        m_vld   = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    logic        m_busy  = 1'b0;

    function automatic logic [31:0] napot_mask(input logic [7:0] c,
                                               input logic [31:0] a);
        int t = 0;
        if (c[4:3] != 2'b11) return 32'hFFFF_FFFF;
        while (t < 32 && a[t]) t++;
        if (t >= 31) return 32'h0;
        return 32'hFFFF_FFFF << (t + 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cfg[i]  = 8'h00;
            m_addr[i] = 32'h0;
            m_mask[i] = 32'hFFFF_FFFF;
        end
        m_vld = 0; m_rdata = 0; m_err = 0; m_busy = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            logic acc, commit;
            int k, idx;
            logic [7:0] b;
            acc    = csr_req_vld && (!m_vld || csr_rsp_rdy);
            commit = 0;
            for (int i = 0; i < N; i++)
                m_mask[i] = napot_mask(m_cfg[i], m_addr[i]);
            if (acc) begin
                m_vld = 1; m_rdata = 0; m_err = 0;
                if (csr_req_addr >= 12'h3A0 && csr_req_addr <= 12'h3AF) begin
                    k = int'(csr_req_addr) - 'h3A0;
                    for (int j = 0; j < 4; j++) begin
                        idx = 4 * k + j;
                        if (idx < N) begin
                            if (!csr_req_wr) begin
                                m_rdata[8*j +: 8] = m_cfg[idx];
                            end else if (!m_cfg[idx][7]) begin
                                b = csr_req_wdata[8*j +: 8];
                                b[6:5] = 2'b00;
                                if (b[1] && !b[0]) b[1] = 1'b0;
                                m_cfg[idx] = b;
                                commit = 1;
                            end
                        end
                    end
                end else if (csr_req_addr >= 12'h3B0 && csr_req_addr <= 12'h3EF) begin
                    idx = int'(csr_req_addr) - 'h3B0;
                    if (idx < N) begin
                        if (!csr_req_wr) begin
                            m_rdata = m_addr[idx];
                        end else if (!(m_cfg[idx][7] ||
                                       (idx + 1 < N && m_cfg[idx+1][7] &&
                                        m_cfg[idx+1][4:3] == 2'b01))) begin
                            m_addr[idx] = csr_req_wdata;
                            commit = 1;
                        end
                    end
                end else begin
                    m_err = 1;
                end
            end else if (csr_rsp_rdy) begin
                m_vld = 0;
            end
            m_busy = commit;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            logic [7:0] c;
            chk("req_rdy", 32'(csr_req_rdy), 32'(!m_vld || csr_rsp_rdy));
            chk("rsp_vld", 32'(csr_rsp_vld), 32'(m_vld));
            if (m_vld) begin
                chk("rsp_rdata", csr_rsp_rdata, m_rdata);
                chk("rsp_err", 32'(csr_rsp_err), 32'(m_err));
            end
            chk("busy", 32'(pmp_upd_busy), 32'(m_busy));
            for (int i = 0; i < N; i++) begin
                c = v_pmp_cfg[i];
                chk($sformatf("cfg%0d", i), 32'(c), 32'(m_cfg[i]));
                chk($sformatf("addr%0d", i), v_pmp_addr[i], m_addr[i]);
                chk($sformatf("mask%0d", i), v_pmp_napot_mask[i], m_mask[i]);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_vld", 32'(csr_rsp_vld), 32'h0);
        chk("rst_req_rdy", 32'(csr_req_rdy), 32'h1);
        chk("rst_busy", 32'(pmp_upd_busy), 32'h0);
    endtask

    // Called just after a falling edge; returns one falling edge after the accept.
    task automatic txn(input logic wr, input logic [11:0] a,
                       input logic [31:0] d);
        int n = 0;
        csr_req_vld = 1'b1; csr_req_wr = wr;
        csr_req_addr = a; csr_req_wdata = d;
        #1;
        while (!csr_req_rdy && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) chk("txn_timeout", 32'(n), 32'h0);
        @(negedge clk);
        csr_req_vld = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            c = v_pmp_cfg[i];
            chk("init_cfg", 32'(c), 32'h0);
            chk("init_addr", v_pmp_addr[i], 32'h0);
            chk("init_mask", v_pmp_napot_mask[i], 32'hFFFF_FFFF);
        end
        chk("init_rsp_vld", 32'(csr_rsp_vld), 32'h0);
        chk("init_req_rdy", 32'(csr_req_rdy), 32'h1);
        @(negedge clk);

        txn(1, 12'h3B3, 32'h0000_1FFF);
        txn(1, 12'h3A0, 32'h1800_0000);
        chk("napot_busy_on", 32'(pmp_upd_busy), 32'h1);
        c = v_pmp_cfg[3];
        chk("napot_cfg3", 32'(c), 32'h18);
        chk("napot_mask_old", v_pmp_napot_mask[3], 32'hFFFF_FFFF);
        @(negedge clk);
        chk("napot_busy_off", 32'(pmp_upd_busy), 32'h0);
        chk("napot_mask3", v_pmp_napot_mask[3], 32'hFFFF_C000);
        txn(0, 12'h3A0, 32'h0);
        chk("napot_readback", csr_rsp_rdata, 32'h1800_0000);

        txn(1, 12'h3A0, 32'h0000_8F00);
        txn(1, 12'h3B0, 32'h0000_0100);
        chk("lock_busy0", 32'(pmp_upd_busy), 32'h0);
        txn(1, 12'h3B1, 32'h0000_0200);
        chk("lock_busy1", 32'(pmp_upd_busy), 32'h0);
        chk("lock_addr0", v_pmp_addr[0], 32'h0);
        chk("lock_addr1", v_pmp_addr[1], 32'h0);
        txn(0, 12'h3A0, 32'h0);
        chk("lock_readback", csr_rsp_rdata, 32'h0000_8F00);

        txn(1, 12'h3A1, 32'h0000_0002);
        txn(0, 12'h3A1, 32'h0);
        chk("warl_w_only", csr_rsp_rdata, 32'h0000_0000);
        txn(1, 12'h3A1, 32'h0000_0067);
        txn(0, 12'h3A1, 32'h0);
        chk("warl_rsvd", csr_rsp_rdata, 32'h0000_0007);

        txn(0, 12'h3F0, 32'h0);
        chk("illegal_err", 32'(csr_rsp_err), 32'h1);
        chk("illegal_rdata", csr_rsp_rdata, 32'h0);
        txn(0, 12'h3B0 + 12'd40, 32'h0);
        chk("unimpl_err", 32'(csr_rsp_err), 32'h0);
        chk("unimpl_rdata", csr_rsp_rdata, 32'h0);

        txn(0, 12'h3A0, 32'h0);
        csr_rsp_rdy = 1'b0;
        csr_req_vld = 1'b1; csr_req_wr = 1'b0; csr_req_addr = 12'h3A1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req_rdy", 32'(csr_req_rdy), 32'h0);
            chk("stall_rsp_vld", 32'(csr_rsp_vld), 32'h1);
            chk("stall_rdata", csr_rsp_rdata, 32'h0000_8F00);
            @(negedge clk);
        end
        csr_rsp_rdy = 1'b1;
        #1;
        chk("release_req_rdy", 32'(csr_req_rdy), 32'h1);
        @(negedge clk);
        csr_req_vld = 1'b0;
        chk("release_rdata", csr_rsp_rdata, 32'h0000_0007);
        @(negedge clk);

        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc % 700 == 699) begin
                csr_req_vld = 1'b1;
                do_reset();
            end else begin
                int sel;
                logic [31:0] d;
                sel = $urandom_range(0, 9);
                csr_rsp_rdy = ($urandom_range(0, 3) != 0);
                csr_req_vld = ($urandom_range(0, 2) != 0);
                csr_req_wr  = ($urandom_range(0, 1) != 0);
                if (sel < 4)
                    csr_req_addr = 12'h3A0 + 12'($urandom_range(0, 15));
                else if (sel < 8)
                    csr_req_addr = 12'h3B0 + 12'($urandom_range(0, 63));
                else
                    csr_req_addr = 12'($urandom);
                d = $urandom;
                if (sel < 4 && $urandom_range(0, 15) != 0)
                    d = d & 32'h7F7F_7F7F;
                if (sel >= 4 && sel < 8 && $urandom_range(0, 1) == 0)
                    d = 32'hFFFF_FFFF >> $urandom_range(0, 31);
                csr_req_wdata = d;
            end
        end
        @(negedge clk);
        csr_req_vld = 1'b0;
        csr_rsp_rdy = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
